// File: rtl/irq_pkg.sv
// Shared interrupt-path definitions: config register offsets for the
// pending/conditioning stage and the downstream mask stage.
package irq_pkg;

  localparam logic [31:0] IRQ_PEND_EDGE  = 32'h0000_0000;
  localparam logic [31:0] IRQ_PEND_POL   = 32'h0000_0004;
  localparam logic [31:0] IRQ_PEND_PEND  = 32'h0000_0008;
  localparam logic [31:0] IRQ_PEND_RAW   = 32'h0000_000C;
  localparam logic [31:0] IRQ_PEND_SWSET = 32'h0000_0010;

  localparam logic [31:0] IRQ_MASK       = 32'h0000_0000;

  // Decoded register selection for the pending stage
  typedef enum logic [2:0] {
    REG_EDGE,
    REG_POL,
    REG_PEND,
    REG_RAW,
    REG_SWSET,
    REG_NONE
  } pend_reg_e;

endpackage

// File: rtl/irq_sync.sv
// Parameterised-width two-flop synchroniser, async active-low reset.
module irq_sync #(
  parameter int unsigned W = 1
) (
  input  logic         c_clk,
  input  logic         c_rstb,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two-stage capture of the asynchronous inputs
  always_ff @(posedge c_clk or negedge c_rstb) begin
    if (!c_rstb) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/irq_pend.sv
// Interrupt source conditioning: synchronise, apply polarity, then per source
// pass the level or latch rising edges into a W1C pending register.
// Optional macro IRQ_PEND_SWSET_EN adds a write-1-to-set register at 0x10.
module irq_pend
  import irq_pkg::*;
#(
  parameter int unsigned MSB = 4
) (
  input  logic         c_clk,
  input  logic         c_rstb,
  input  logic [MSB:0] src,
  output logic [MSB:0] pend,
  output logic         c_ready,
  output logic [31:0]  c_rdata,
  input  logic [31:0]  c_wdata,
  input  logic         c_write,
  input  logic [31:0]  c_addr,
  input  logic [1:0]   c_size,
  input  logic         c_valid
);

  logic [MSB:0] sync;
  logic [MSB:0] act;
  logic [MSB:0] hist;
  logic [MSB:0] rise;
  logic [MSB:0] edge_q;
  logic [MSB:0] pol_q;
  logic [MSB:0] clr;
  logic [MSB:0] set;
  logic [MSB:0] pend_nxt;
  logic [31:0]  wr_al;
  logic [31:0]  rd_q;
  logic [31:0]  rd_nxt;
  logic         wr_en;
  logic         rd_en;
  pend_reg_e    sel;
  logic         unused;

  irq_sync #(.W(MSB + 1)) u_sync (
    .c_clk  (c_clk),
    .c_rstb (c_rstb),
    .d      (src),
    .q      (sync)
  );

  assign act    = sync ^ pol_q;
  assign rise   = act & ~hist;
  assign wr_al  = c_wdata << {c_addr[1:0], 3'b000};
  assign wr_en  = c_valid & c_write;
  assign rd_en  = c_valid & ~c_write;
  assign unused = ^{c_size, wr_al[31:MSB+1]};

  // Word-offset decode of the config address
  always_comb begin
    sel = REG_NONE;
    case (c_addr & ~32'h3)
      IRQ_PEND_EDGE:  sel = REG_EDGE;
      IRQ_PEND_POL:   sel = REG_POL;
      IRQ_PEND_PEND:  sel = REG_PEND;
      IRQ_PEND_RAW:   sel = REG_RAW;
`ifdef IRQ_PEND_SWSET_EN
      IRQ_PEND_SWSET: sel = REG_SWSET;
`endif
      default:        sel = REG_NONE;
    endcase
  end

  // Clear/set strobes and next pending vector; any set beats a same-cycle clear
  always_comb begin
    clr = '0;
    set = rise;
    if (wr_en && sel == REG_PEND) clr = wr_al[MSB:0];
`ifdef IRQ_PEND_SWSET_EN
    if (wr_en && sel == REG_SWSET) set = rise | wr_al[MSB:0];
`endif
    pend_nxt = (edge_q & (set | (pend & ~clr))) | (~edge_q & act);
  end

  // Read mux; unmapped offsets leave the read register as it was
  always_comb begin
    rd_nxt = rd_q;
    case (sel)
      REG_EDGE:  rd_nxt = 32'(edge_q);
      REG_POL:   rd_nxt = 32'(pol_q);
      REG_PEND:  rd_nxt = 32'(pend);
      REG_RAW:   rd_nxt = 32'(sync);
      REG_SWSET: rd_nxt = '0;
      default:   rd_nxt = rd_q;
    endcase
  end

  // Edge history and pending output
  always_ff @(posedge c_clk or negedge c_rstb) begin
    if (!c_rstb) begin
      hist <= '0;
      pend <= '0;
    end else begin
      hist <= act;
      pend <= pend_nxt;
    end
  end

  // Mode and polarity registers
  always_ff @(posedge c_clk or negedge c_rstb) begin
    if (!c_rstb) begin
      edge_q <= '0;
      pol_q  <= '0;
    end else if (wr_en) begin
      if (sel == REG_EDGE) edge_q <= wr_al[MSB:0];
      if (sel == REG_POL)  pol_q  <= wr_al[MSB:0];
    end
  end

  // Config response: ready one cycle after valid, read data captured on valid
  always_ff @(posedge c_clk or negedge c_rstb) begin
    if (!c_rstb) begin
      c_ready <= 1'b0;
      rd_q    <= '0;
    end else begin
      c_ready <= c_valid;
      if (rd_en) rd_q <= rd_nxt;
    end
  end

  assign c_rdata = rd_q >> {c_addr[1:0], 3'b000};

endmodule

// File: tb/tb_irq_pend.sv
// Self-checking bench for irq_pend: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
// Honours IRQ_PEND_SWSET_EN when defined.
module tb_irq_pend;

  localparam int MSB = 4;
  localparam int N   = MSB + 1;

  logic          c_clk   = 1'b0;
  logic          c_rstb  = 1'b0;
  logic [N-1:0]  src     = '0;
  logic [N-1:0]  pend;
  logic          c_ready;
  logic [31:0]   c_rdata;
  logic [31:0]   c_wdata = '0;
  logic          c_write = 1'b0;
  logic [31:0]   c_addr  = '0;
  logic [1:0]    c_size  = 2'b10;
  logic          c_valid = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 c_clk = ~c_clk;

  irq_pend #(.MSB(MSB)) dut (
    .c_clk   (c_clk),
    .c_rstb  (c_rstb),
    .src     (src),
    .pend    (pend),
    .c_ready (c_ready),
    .c_rdata (c_rdata),
    .c_wdata (c_wdata),
    .c_write (c_write),
    .c_addr  (c_addr),
    .c_size  (c_size),
    .c_valid (c_valid)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Sources seen through a two-sample delay line; each bit evaluated
  // independently from the mode/polarity rules.
  logic [N-1:0] m_s1, m_s2, m_hist, m_edge, m_pol, m_pend;
  logic         m_ready;
  logic [31:0]  m_rd;

  always @(posedge c_clk or negedge c_rstb) begin
    if (!c_rstb) begin
      m_s1 <= '0; m_s2 <= '0; m_hist <= '0; m_edge <= '0;
      m_pol <= '0; m_pend <= '0; m_ready <= 1'b0; m_rd <= '0;
    end else begin
      automatic logic [31:0] wal;
      automatic logic [31:0] off;
      automatic logic [N-1:0] a;
      automatic logic [N-1:0] np;
      automatic bit r, cl, st;
      wal = c_wdata << (8 * c_addr[1:0]);
      off = c_addr & 32'hFFFF_FFFC;
      a   = m_s2 ^ m_pol;
      np  = '0;
      for (int i = 0; i < N; i++) begin
        r  = a[i] && !m_hist[i];
        cl = c_valid && c_write && off == 32'h8 && wal[i];
        st = 1'b0;
`ifdef IRQ_PEND_SWSET_EN
        st = c_valid && c_write && off == 32'h10 && wal[i];
`endif
        if (m_edge[i]) np[i] = r || st || (m_pend[i] && !cl);
        else           np[i] = a[i];
      end
      m_pend  <= np;
      m_hist  <= a;
      m_s2    <= m_s1;
      m_s1    <= src;
      m_ready <= c_valid;
      if (c_valid && c_write) begin
        if (off == 32'h0) m_edge <= wal[N-1:0];
        if (off == 32'h4) m_pol  <= wal[N-1:0];
      end
      if (c_valid && !c_write) begin
        case (off)
          32'h0:  m_rd <= 32'(m_edge);
          32'h4:  m_rd <= 32'(m_pol);
          32'h8:  m_rd <= 32'(m_pend);
          32'hC:  m_rd <= 32'(m_s2);
`ifdef IRQ_PEND_SWSET_EN
          32'h10: m_rd <= 32'h0;
`endif
          default: m_rd <= m_rd;
        endcase
      end
    end
  end

  // Continuous comparison against the model on the falling edge
  always @(negedge c_clk) begin
    check("pend", 32'(pend), 32'(m_pend));
    check("ready", 32'(c_ready), 32'(m_ready));
    if (m_ready) check("rdata", c_rdata, m_rd >> (8 * c_addr[1:0]));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic cfg_write(input logic [31:0] a, input logic [31:0] d);
    c_valid = 1'b1; c_write = 1'b1; c_addr = a; c_wdata = d;
    tick();
    c_valid = 1'b0; c_write = 1'b0;
    tick();
  endtask

  task automatic cfg_read(input logic [31:0] a, output logic [31:0] d);
    c_valid = 1'b1; c_write = 1'b0; c_addr = a;
    tick();
    c_valid = 1'b0;
    check("rd_ready", 32'(c_ready), 32'h1);
    d = c_rdata;
    tick();
  endtask

  logic [31:0] rd;
  bit          prev_valid;

  initial begin
    // Reset with all sources asserted
    src = 5'h1F;
    tick(); tick();
    check("rst_pend", 32'(pend), 32'h0);
    check("rst_ready", 32'(c_ready), 32'h0);
    @(negedge c_clk);
    c_rstb = 1'b1;
    tick(); check("lat_e1", 32'(pend), 32'h0);
    tick(); check("lat_e2", 32'(pend), 32'h0);
    tick(); check("lat_e3", 32'(pend), 32'h1F);
    cfg_read(32'hC, rd);
    check("raw_read", rd, 32'h1F);

    // Edge mode: single-cycle pulse latches, W1C clears
    src = '0;
    repeat (4) tick();
    check("level_low", 32'(pend), 32'h0);
    cfg_write(32'h0, 32'h3);
    src = 5'h01;
    tick();
    src = '0;
    tick(); check("edge_e2", 32'(pend[0]), 32'h0);
    tick(); check("edge_e3", 32'(pend[0]), 32'h1);
    repeat (3) tick();
    check("edge_hold", 32'(pend[0]), 32'h1);
    cfg_write(32'h8, 32'h1);
    check("w1c_clear", 32'(pend[0]), 32'h0);

    // Rise and W1C on the same edge: set wins
    src = 5'h02;
    tick(); tick();
    c_valid = 1'b1; c_write = 1'b1; c_addr = 32'h8; c_wdata = 32'h2;
    tick();
    c_valid = 1'b0; c_write = 1'b0;
    check("set_wins", 32'(pend[1]), 32'h1);
    tick();
    cfg_write(32'h8, 32'h2);
    check("w1c_after_set", 32'(pend[1]), 32'h0);
    src = '0;
    repeat (3) tick();

    // Polarity in level mode
    cfg_write(32'h4, 32'h4);
    cfg_write(32'h0, 32'h0);
    repeat (3) tick();
    check("pol_low_active", 32'(pend), 32'h4);
    cfg_write(32'h8, 32'h4);
    check("level_w1c_noop", 32'(pend), 32'h4);
    src = 5'h04;
    tick(); tick();
    check("pol_e2", 32'(pend[2]), 32'h1);
    tick();
    check("pol_e3", 32'(pend[2]), 32'h0);

    // Byte lanes
    cfg_write(32'h0, 32'h1F);
    cfg_write(32'h1, 32'h1);
    cfg_read(32'h0, rd);
    check("lane_edge", rd, 32'h0);
    src = '0;
    cfg_write(32'h4, 32'h0);
    repeat (4) tick();
    cfg_write(32'h0, 32'h1F);
    cfg_write(32'h8, 32'h1F);
    check("pend_clean", 32'(pend), 32'h0);
    src = 5'h13;
    tick();
    src = '0;
    repeat (4) tick();
    check("pend_13", 32'(pend), 32'h13);
    cfg_read(32'h8, rd);
    check("read_pend", rd, 32'h13);
    cfg_read(32'h9, rd);
    check("read_lane1", rd, 32'h0);

    // Software set register
    cfg_write(32'h8, 32'h1F);
`ifdef IRQ_PEND_SWSET_EN
    c_valid = 1'b1; c_write = 1'b1; c_addr = 32'h10; c_wdata = 32'h0A;
    tick();
    c_valid = 1'b0; c_write = 1'b0;
    check("swset_next", 32'(pend), 32'h0A);
    tick();
    cfg_write(32'h10, 32'h1);
    check("swset_bit0", 32'(pend), 32'h0B);
    cfg_read(32'h10, rd);
    check("swset_read0", rd, 32'h0);
    cfg_write(32'h8, 32'h1F);
`else
    cfg_write(32'h10, 32'h0A);
    check("swset_absent", 32'(pend), 32'h0);
`endif

    // Randomized traffic with one asynchronous reset mid-run
    prev_valid = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (k == 1500) begin
        c_valid = 1'b0;
        #2 c_rstb = 1'b0;
        #1 check("async_rst", 32'(pend), 32'h0);
        tick();
        c_rstb = 1'b1;
        prev_valid = 1'b0;
      end
      src = N'($urandom);
      if (!prev_valid)
        c_addr = 32'($urandom_range(0, 5) * 4) | 32'($urandom_range(0, 3));
      c_valid = ($urandom_range(0, 2) == 0);
      c_write = $urandom_range(0, 1) == 1;
      c_wdata = $urandom;
      prev_valid = c_valid;
      tick();
    end
    c_valid = 1'b0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
